// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller, the async receiver and
// the APB register layer. The controller connects through the slave modport;
// the receiver/host side (or a bench) connects through the master modport.
// Optional build macro: UART_RX_TIMEOUT_EN adds the RX_TIMEOUT output.
//
// Handshakes:
//   Receiver side: RX_RDY_IN is a level "byte valid". The controller answers
//   with a one-cycle RX_READ_OUT (and PARITY_CLR_OUT when the byte carried a
//   parity error) and will not take another byte until RX_RDY_IN has been low.
//   Host side: first-word-fall-through. RD_DATA/RD_PERR show the head entry
//   whenever FIFO_EMPTY=0 (valid = !FIFO_EMPTY); POP is the ready/accept and
//   consumes the head on the clock edge where POP=1 and FIFO_EMPTY=0.
interface uart_rx_ctrl_if #(
    parameter int BAUD_W  = 13,
    parameter int FIFO_AW = 4
);
    logic               RX_ENABLE;
    logic [BAUD_W-1:0]  BAUD_VAL;
    logic               BAUD_TICK;
    logic               RX_RDY_IN;
    logic [7:0]         RX_DATA_IN;
    logic               PARITY_ERR_IN;
    logic               FRAMING_ERR_IN;
    logic               RX_READ_OUT;
    logic               PARITY_CLR_OUT;
    logic               POP;
    logic [7:0]         RD_DATA;
    logic               RD_PERR;
    logic               FIFO_EMPTY;
    logic               FIFO_FULL;
    logic [FIFO_AW:0]   FIFO_LEVEL;
    logic [FIFO_AW:0]   RX_THRESH;
    logic               RX_IRQ;
    logic               OVF_STICKY;
    logic               FE_STICKY;
    logic               CLR_ERR;
    logic [1:0]         DBG_STATE;
`ifdef UART_RX_TIMEOUT_EN
    logic               RX_TIMEOUT;

    modport slave (
        input  RX_ENABLE, BAUD_VAL, RX_RDY_IN, RX_DATA_IN, PARITY_ERR_IN,
               FRAMING_ERR_IN, POP, RX_THRESH, CLR_ERR,
        output BAUD_TICK, RX_READ_OUT, PARITY_CLR_OUT, RD_DATA, RD_PERR,
               FIFO_EMPTY, FIFO_FULL, FIFO_LEVEL, RX_IRQ, OVF_STICKY,
               FE_STICKY, DBG_STATE, RX_TIMEOUT
    );

    modport master (
        output RX_ENABLE, BAUD_VAL, RX_RDY_IN, RX_DATA_IN, PARITY_ERR_IN,
               FRAMING_ERR_IN, POP, RX_THRESH, CLR_ERR,
        input  BAUD_TICK, RX_READ_OUT, PARITY_CLR_OUT, RD_DATA, RD_PERR,
               FIFO_EMPTY, FIFO_FULL, FIFO_LEVEL, RX_IRQ, OVF_STICKY,
               FE_STICKY, DBG_STATE, RX_TIMEOUT
    );
`else
    modport slave (
        input  RX_ENABLE, BAUD_VAL, RX_RDY_IN, RX_DATA_IN, PARITY_ERR_IN,
               FRAMING_ERR_IN, POP, RX_THRESH, CLR_ERR,
        output BAUD_TICK, RX_READ_OUT, PARITY_CLR_OUT, RD_DATA, RD_PERR,
               FIFO_EMPTY, FIFO_FULL, FIFO_LEVEL, RX_IRQ, OVF_STICKY,
               FE_STICKY, DBG_STATE
    );

    modport master (
        output RX_ENABLE, BAUD_VAL, RX_RDY_IN, RX_DATA_IN, PARITY_ERR_IN,
               FRAMING_ERR_IN, POP, RX_THRESH, CLR_ERR,
        input  BAUD_TICK, RX_READ_OUT, PARITY_CLR_OUT, RD_DATA, RD_PERR,
               FIFO_EMPTY, FIFO_FULL, FIFO_LEVEL, RX_IRQ, OVF_STICKY,
               FE_STICKY, DBG_STATE
    );
`endif
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x baud enable generator, capture FSM that moves
// each received byte (with its parity flag) into a 16-entry FWFT FIFO and
// acknowledges the receiver, sticky overflow/framing flags and a registered
// FIFO-threshold interrupt.
// Optional build macro: UART_RX_TIMEOUT_EN adds an idle-FIFO timeout flag.
module uart_rx_ctrl #(
    parameter int BAUD_W  = 13,
    parameter int FIFO_AW = 4
) (
    input logic           CLK,
    input logic           RESET,
    uart_rx_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CAPTURE  = 2'd1,
        S_WAIT_CLR = 2'd2
    } state_t;

    // Baud generator
    logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic               tick_q, tick_d;

    // Capture FSM
    state_t             state_q, state_d;
    logic               fifo_wr;
    logic               read_pulse;
    logic               pclr_pulse;
    logic               ovf_set;

    // FIFO
    logic [8:0]         mem_q [DEPTH];
    logic [8:0]         mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop_ok;

    // Status
    logic               irq_q, irq_d;
    logic               ovf_q, ovf_d;
    logic               fe_q, fe_d;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);
    // An empty FIFO has no head, so a pop there is simply dropped.
    assign pop_ok     = bus.POP && !fifo_empty;

    // Baud down-counter: tick on zero then reload, held at BAUD_VAL while disabled.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        tick_d     = 1'b0;
        if (!bus.RX_ENABLE) begin
            baud_cnt_d = bus.BAUD_VAL;
        end else if (baud_cnt_q == '0) begin
            baud_cnt_d = bus.BAUD_VAL;
            tick_d     = 1'b1;
        end else begin
            baud_cnt_d = baud_cnt_q - 1'b1;
        end
    end

    // Baud generator registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            baud_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            tick_q     <= tick_d;
        end
    end

    // Capture FSM next state and pulses; WAIT_CLR blocks a re-capture of the same byte.
    always_comb begin
        state_d    = state_q;
        fifo_wr    = 1'b0;
        read_pulse = 1'b0;
        pclr_pulse = 1'b0;
        ovf_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.RX_ENABLE && bus.RX_RDY_IN) begin
                    if (!fifo_full) begin
                        state_d = S_CAPTURE;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                fifo_wr    = 1'b1;
                read_pulse = 1'b1;
                pclr_pulse = bus.PARITY_ERR_IN;
                state_d    = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                if (!bus.RX_RDY_IN) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO storage, pointers and occupancy; write and pop may coincide.
    always_comb begin
        mem_d = mem_q;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = {bus.PARITY_ERR_IN, bus.RX_DATA_IN};
        end
        wr_ptr_d = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({fifo_wr, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Threshold interrupt and sticky flags; a set beats a same-cycle clear.
    always_comb begin
        irq_d = (bus.RX_THRESH != '0) && (level_q >= bus.RX_THRESH);
        ovf_d = ovf_set || (ovf_q && !bus.CLR_ERR);
        fe_d  = bus.FRAMING_ERR_IN || (fe_q && !bus.CLR_ERR);
    end

    // Status registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            irq_q <= 1'b0;
            ovf_q <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            irq_q <= irq_d;
            ovf_q <= ovf_d;
            fe_q  <= fe_d;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    // 4 characters x 10 bits x 16 ticks per bit.
    localparam logic [10:0] TO_LIMIT = 11'd640;
    logic [10:0] to_cnt_q, to_cnt_d;

    // Idle timeout: count baud ticks while data sits untouched, saturate at the limit.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (fifo_wr || bus.POP || bus.CLR_ERR || fifo_empty) begin
            to_cnt_d = '0;
        end else if (tick_q && (to_cnt_q != TO_LIMIT)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign bus.RX_TIMEOUT = (to_cnt_q == TO_LIMIT);
`endif

    assign bus.BAUD_TICK      = tick_q;
    assign bus.RX_READ_OUT    = read_pulse;
    assign bus.PARITY_CLR_OUT = pclr_pulse;
    assign bus.RD_DATA        = fifo_empty ? 8'h00 : mem_q[rd_ptr_q][7:0];
    assign bus.RD_PERR        = fifo_empty ? 1'b0  : mem_q[rd_ptr_q][8];
    assign bus.FIFO_EMPTY     = fifo_empty;
    assign bus.FIFO_FULL      = fifo_full;
    assign bus.FIFO_LEVEL     = level_q;
    assign bus.RX_IRQ         = irq_q;
    assign bus.OVF_STICKY     = ovf_q;
    assign bus.FE_STICKY      = fe_q;
    assign bus.DBG_STATE      = state_q;
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller for the UART core: generates the 16x baud enable for the async receiver, and drains each received byte plus its parity status into a small status-tagged FIFO.
- Issues the read-clear handshake back to the receiver.
- Presents a first-word-fall-through pop interface, sticky error flags and a threshold interrupt to the APB register layer.

Parameters:
- BAUD_W, 13, width of baud divisor.
- FIFO_AW, 4, log2 FIFO depth (16 entries, each 9 bits: parity_err + data[7:0]).

Ports:
- CLK  in  1  system clock
- RESET  in  1  async active-high reset
- RX_ENABLE  in  1  enables baud generator and capture FSM
- BAUD_VAL  in  BAUD_W  divisor; tick period = BAUD_VAL+1 cycles
- BAUD_TICK  out  1  one-cycle 16x-baud enable to receiver
- RX_RDY_IN  in  1  receiver data-ready (level)
- RX_DATA_IN  in  8  receiver data byte
- PARITY_ERR_IN  in  1  receiver sticky parity error
- FRAMING_ERR_IN  in  1  receiver framing-error pulse
- RX_READ_OUT  out  1  one-cycle read/clear pulse to receiver
- PARITY_CLR_OUT  out  1  one-cycle parity-clear pulse to receiver
- POP  in  1  host pop request
- RD_DATA  out  8  head-entry data (FWFT)
- RD_PERR  out  1  head-entry parity flag
- FIFO_EMPTY  out  1
- FIFO_FULL  out  1
- FIFO_LEVEL  out  FIFO_AW+1  occupancy 0..2^FIFO_AW
- RX_THRESH  in  FIFO_AW+1  interrupt threshold
- RX_IRQ  out  1  registered: FIFO_LEVEL >= RX_THRESH and RX_THRESH != 0
- OVF_STICKY  out  1  byte left waiting because FIFO full
- FE_STICKY  out  1  framing error seen
- CLR_ERR  in  1  clears OVF_STICKY, FE_STICKY

Behaviour:
- Reset:
  - All outputs 0 except FIFO_EMPTY=1.
  - Pointers, level and baud counter are cleared.
  - FSM enters IDLE.
- Baud generator:
  - Down-counter loaded with BAUD_VAL; BAUD_TICK=1 for one cycle when the counter is 0, then the counter reloads.
  - BAUD_VAL=0 gives a tick every cycle.
  - RX_ENABLE=0: counter forced to BAUD_VAL, BAUD_TICK=0.
  - A BAUD_VAL change takes effect at the next reload.
- Capture FSM, states IDLE, CAPTURE, WAIT_CLR:
  - IDLE -> CAPTURE when RX_ENABLE & RX_RDY_IN & !FIFO_FULL.
  - CAPTURE (1 cycle):
    - Writes {PARITY_ERR_IN, RX_DATA_IN} into the FIFO.
    - Pulses RX_READ_OUT.
    - Pulses PARITY_CLR_OUT only if PARITY_ERR_IN=1.
    - Goes to WAIT_CLR.
  - WAIT_CLR -> IDLE once RX_RDY_IN=0; this prevents a double capture.
  - Latency: RX_RDY_IN rise to FIFO_EMPTY fall is 2 cycles.
  - RX_RDY_IN=1 with FIFO_FULL: FSM stays in IDLE, no RX_READ_OUT, OVF_STICKY set. Capture resumes automatically after a pop.
  - RX_ENABLE deasserted mid-operation: CAPTURE still completes; WAIT_CLR still waits for RX_RDY_IN=0.
- FIFO:
  - Pointers FIFO_AW bits, wrap naturally; level FIFO_AW+1 bits.
  - POP when empty: ignored.
  - Write when full: impossible by FSM gating.
  - Simultaneous write and pop: both occur, level unchanged.
  - Pop and write on an empty FIFO: pop ignored, write occurs.
  - RD_DATA/RD_PERR read 0 when empty; head is visible the cycle after the write.
- FE_STICKY: set on FRAMING_ERR_IN pulse.
- CLR_ERR: clears OVF_STICKY and FE_STICKY. A set and clear in the same cycle: set wins.
- RX_IRQ: registered, one cycle after a level change.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- When defined: adds output RX_TIMEOUT (1 bit) and an 11-bit tick counter.
  - Counter increments on BAUD_TICK while the FIFO is non-empty.
  - Counter clears on any FIFO write, any pop, CLR_ERR, or when empty.
  - At count 640 (4 chars x 10 bits x 16), RX_TIMEOUT=1 and holds until the counter is cleared; the counter saturates.
- When undefined: no port, no counter; RX_IRQ is threshold-only.

Test Plan:
- Reset, BAUD_VAL=3, RX_ENABLE=1 -> BAUD_TICK every 4th cycle; RX_ENABLE=0 -> BAUD_TICK stays 0.
- RX_RDY_IN=1, RX_DATA_IN=0xA5, PARITY_ERR_IN=0 -> one RX_READ_OUT pulse, no PARITY_CLR_OUT; 2 cycles later RD_DATA=0xA5, FIFO_LEVEL=1. RX_RDY_IN held 3 more cycles -> no second write.
- Byte 0x3C with PARITY_ERR_IN=1 -> PARITY_CLR_OUT pulses with RX_READ_OUT; RD_PERR=1 at head.
- Write 16 bytes 0x00..0x0F, 17th RX_RDY_IN held -> FIFO_FULL=1, OVF_STICKY=1, no ack. POP once -> 17th captured; pops return 0x01..0x0F then the 17th byte.
- RX_THRESH=4: fourth write -> RX_IRQ=1 one cycle later. Simultaneous POP and capture at level 4 -> level stays 4, RX_IRQ stays 1.
- UART_RX_TIMEOUT_EN defined, BAUD_VAL=0, one byte in FIFO, no activity -> RX_TIMEOUT=1 after 640 ticks; POP -> RX_TIMEOUT=0 next cycle.
